mc_window_datapath: RTL
=======================

# mc_window_datapath

Multi-cycle, parametrised successor of the single-cycle windowed datapath. It combines the datapath and its own controller FSM. Instructions and data share one memory port with a req/ack handshake. The block adds wait-state tolerance, a configurable data width, a configurable register count and configurable window indexing, plus a HALT state.

## Interface
- DW, 16: data/register width; must be ≥16; instructions use mem_rdata[15:0]
- AW, 12: PC/address width; 8 ≤ AW ≤ 12
- NREG, 8: register count; power of two, ≥4; WB = log2(NREG)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; leaves IDLE
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  AW  word address
- mem_wdata  out  DW  store data
- mem_rdata  in  DW  read data, valid with mem_ack
- mem_ack  in  1  completes the pending request
- pc  out  AW  current PC
- zero  out  1  ALU zero flag
- halted  out  1  high in HALT state

## Operation
- Fields:
  - op = ins[15:12]
  - fa = ins[11:10]
  - fb = ins[9:8]
  - imm8 = ins[7:0]
  - addr = ins[AW-1:0]
- Register index: (field + wnd) mod NREG.
  - wnd is a WB-bit window register.
  - LDA/STA always use field 0.
- Opcodes:
  - 0000 LDA: R[0+wnd] ← M[addr]
  - 0001 STA: M[addr] ← R[0+wnd]
  - 0010 JMP: PC ← addr
  - 0011 BZ: if zero, PC ← {PCinc[AW-1:8], imm8}
  - 1000 ALU: R[fa] ← R[fa] op R[fb]
    - funct ins[2:0]: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not fb, 110 mov fb, 111 pass fa
  - 1100 ADDI: R[fa] ← R[fa] + sext(imm8)
  - 1110 WIN: wnd ← ins[WB-1:0]
  - 1111 HALT
  - Any other opcode: NOP
- Arithmetic is modulo 2^DW.
- zero is updated only by ALU and ADDI, and is set when the written result equals 0.
- FSM states:
  - IDLE → FETCH on start.
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On ack: IR ← rdata[15:0], PC ← PC+1 (wraps mod 2^AW), go to DECODE.
  - DECODE: latch A=R[fa'], B=R[fb'].
    - JMP, BZ, WIN, NOP complete here and go to FETCH.
    - HALT goes to HALT.
    - LDA/STA go to MEM.
    - ALU/ADDI go to EXEC.
  - EXEC: write register and zero, go to FETCH.
  - MEM: mem_req=1, mem_addr=addr, mem_we=(op==STA), mem_wdata=A. On ack: LDA writes rdata, go to FETCH.
  - HALT: terminal until rst; start is ignored.
- mem_ack while mem_req=0 is ignored.
- Register writes and PC updates happen only at the listed points.

## Timing
- Reset values:
  - state=IDLE, PC=0, wnd=0, all registers 0, zero=0, halted=0
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
- Outputs are registered or decoded from registered state; there is no mem_rdata→mem_req combinational path.
- mem_req, mem_we, mem_addr and mem_wdata are held stable from assertion until the cycle mem_ack=1 inclusive.
- Request is deasserted the cycle after ack unless the next state issues a new request.
- Latency with zero wait (ack in first req cycle):
  - ALU/ADDI/LDA/STA: 3 cycles
  - JMP/BZ/WIN/NOP: 2 cycles
  - Each wait cycle adds 1.
- start is accepted only in IDLE. A start in the same cycle as rst is lost.
- rst mid-transaction clears mem_req asynchronously. Any partial write is discarded and no register or PC update occurs.
- halted rises in the cycle after DECODE of HALT.

## Configuration
- MCDP_WINDOW_EN defined: window register present; indices are (field + wnd) mod NREG; WIN loads wnd.
- MCDP_WINDOW_EN undefined: no wnd register; indices are the raw fields (R0–R3 only); WIN decodes as a 2-cycle NOP.

## Test plan
- Reset, then start pulse → next cycle mem_req=1, mem_addr=0x000, mem_we=0; pc=0 until ack.
- ADDI fa=0,+5; ADDI fa=0,0xFB; BZ imm8=0x20 at PC=2 (ack immediate) → R0=0, zero=1, next fetch mem_addr=0x020.
- WIN 3; ADDI fa=1,+1 → R4=1. WIN 7; ADDI fa=2,+1 → R1=1 (wrap, NREG=8). With the macro off → R1=1, then R2=1.
- STA with R0=0x1234, addr=0x0AB, ack after 3 wait cycles → mem_req, mem_we, mem_addr=0x0AB and mem_wdata=0x1234 held 4 cycles; instruction takes 6 cycles.
- rst asserted mid-FETCH with ack low → mem_req=0 immediately (before the next edge); pc=0, state IDLE.
- HALT at 0x005 → halted=1, no further mem_req, start ignored; rst clears halted.

Source files
------------

// File: rtl/mc_window_datapath.sv
// Multi-cycle windowed accumulator datapath with its controller FSM and one shared req/ack memory port.
// Define MCDP_WINDOW_EN to add the register window (wnd) and the WIN instruction.
module mc_window_datapath #(
    parameter int unsigned DW   = 16,
    parameter int unsigned AW   = 12,
    parameter int unsigned NREG = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [AW-1:0] pc,
    output logic          zero,
    output logic          halted
);
    localparam int unsigned WB = $clog2(NREG);

    localparam logic [3:0] OP_LDA  = 4'h0;
    localparam logic [3:0] OP_STA  = 4'h1;
    localparam logic [3:0] OP_JMP  = 4'h2;
    localparam logic [3:0] OP_BZ   = 4'h3;
    localparam logic [3:0] OP_ALU  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'hC;
    localparam logic [3:0] OP_WIN  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    state_t          state;
    logic [15:0]     ir;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [DW-1:0]   regs [NREG];

    logic [3:0]      op;
    logic [WB-1:0]   idx_a;
    logic [WB-1:0]   idx_b;
    logic [WB-1:0]   idx_0;
    logic [DW-1:0]   alu_res;
    logic [DW-1:0]   exec_res;
    logic [AW-1:0]   bz_target;
    logic [AW-1:0]   next_pc;

    assign op = ir[15:12];

`ifdef MCDP_WINDOW_EN
    logic [WB-1:0] wnd;
    assign idx_a = WB'(ir[11:10]) + wnd;
    assign idx_b = WB'(ir[9:8]) + wnd;
    assign idx_0 = wnd;
`else
    assign idx_a = WB'(ir[11:10]);
    assign idx_b = WB'(ir[9:8]);
    assign idx_0 = '0;
`endif

    // ALU on the operands latched in DECODE
    always_comb begin
        alu_res = a;
        case (ir[2:0])
            3'd0:    alu_res = a + b;
            3'd1:    alu_res = a - b;
            3'd2:    alu_res = a & b;
            3'd3:    alu_res = a | b;
            3'd4:    alu_res = a ^ b;
            3'd5:    alu_res = ~b;
            3'd6:    alu_res = b;
            default: alu_res = a;
        endcase
        exec_res = (op == OP_ADDI) ? (a + {{(DW-8){ir[7]}}, ir[7:0]}) : alu_res;
    end

    // Branch target keeps the upper bits of the already-incremented PC
    always_comb begin
        bz_target      = pc;
        bz_target[7:0] = ir[7:0];
        next_pc        = pc;
        if (op == OP_JMP) begin
            next_pc = ir[AW-1:0];
        end else if ((op == OP_BZ) && zero) begin
            next_pc = bz_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= '0;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            zero      <= 1'b0;
            halted    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef MCDP_WINDOW_EN
            wnd       <= '0;
`endif
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        ir      <= mem_rdata[15:0];
                        pc      <= pc + AW'(1);
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a <= regs[idx_a];
                    b <= regs[idx_b];
                    case (op)
                        OP_LDA, OP_STA: begin
                            state     <= S_MEM;
                            mem_req   <= 1'b1;
                            mem_we    <= (op == OP_STA);
                            mem_addr  <= ir[AW-1:0];
                            mem_wdata <= regs[idx_0];
                        end
                        OP_ALU, OP_ADDI: begin
                            state <= S_EXEC;
                        end
                        OP_HALT: begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                        default: begin
`ifdef MCDP_WINDOW_EN
                            if (op == OP_WIN) begin
                                wnd <= ir[WB-1:0];
                            end
`endif
                            pc       <= next_pc;
                            state    <= S_FETCH;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= next_pc;
                        end
                    endcase
                end
                S_EXEC: begin
                    regs[idx_a] <= exec_res;
                    zero        <= (exec_res == '0);
                    state       <= S_FETCH;
                    mem_req     <= 1'b1;
                    mem_we      <= 1'b0;
                    mem_addr    <= pc;
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            regs[idx_0] <= mem_rdata;
                        end
                        state    <= S_FETCH;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule
